// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the LVDS transmit sequencer: state encoding,
// frame sync patterns and the I/Q sample word packer.
package lvds_tx_pkg;

  localparam int SAMPLE_W = 13;

  localparam logic [1:0]  SYNC_HI    = 2'b10;
  localparam logic [1:0]  SYNC_LO    = 2'b01;
  localparam logic [31:0] END_MARKER = 32'h8000_4000;
  localparam logic [31:0] IDLE_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREPARE  = 2'd1,
    ST_TRANSMIT = 2'd2
  } tx_state_e;

  // Each half carries a sync pair and a marker bit so the receiver can re-align.
  function automatic logic [31:0] pack_sample(input logic [SAMPLE_W-1:0] i_s,
                                              input logic [SAMPLE_W-1:0] q_s);
    return {SYNC_HI, i_s, 1'b1, SYNC_LO, q_s, 1'b0};
  endfunction

endpackage

// File: rtl/lvds_edge_det.sv
// Registered rising-edge detector. RST_VAL sets the assumed previous level so a
// signal already high at reset release does not look like an edge.
module lvds_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);

  logic sig_q, sig_d;

  always_comb sig_d = i_sig;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= RST_VAL;
    else       sig_q <= sig_d;
  end

  assign o_rise = i_sig & ~sig_q;

endmodule

// File: rtl/lvds_tx_sequencer.sv
// Transmit framing FSM: steps the generator, packs I/Q into frame words on serializer
// word boundaries and hands the sample RAM to the generator while busy.
// Optional sample counter output enabled by defining LVDS_TX_SEQ_SAMPLE_CNT_EN.
module lvds_tx_sequencer
  import lvds_tx_pkg::*;
#(
  parameter int SETTLE_WORDS = 9,
  parameter int CNT_W        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_transmit,
  input  logic                i_word_done,
  input  logic                i_gen_done,
  input  logic [SAMPLE_W-1:0] i_sample_i,
  input  logic [SAMPLE_W-1:0] i_sample_q,
  output logic                o_gen_enable,
  output logic                o_gen_rst,
  output logic                o_ram_owner,
  output logic [31:0]         o_tx_data,
`ifdef LVDS_TX_SEQ_SAMPLE_CNT_EN
  output logic [15:0]         o_sample_cnt,
`endif
  output logic                o_msg_done,
  output logic                o_busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_WORDS - 1);

  tx_state_e        state_q, state_d;
  logic [31:0]      tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trd_q, trd_d;
  logic             trdd_q, trdd_d;
  logic             done_q, done_d;
  logic             gen_en_q, gen_en_d;
  logic             msg_done_q, msg_done_d;
  logic             wb, start, enter_prep, sample_load;

  // Boundary detector starts "high" so a serializer already reporting done at
  // reset release is not mistaken for a fresh word boundary.
  lvds_edge_det #(.RST_VAL(1'b1)) u_wb_det (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (i_word_done),
    .o_rise (wb)
  );

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    cnt_d       = cnt_q;
    trd_d       = trd_q;
    trdd_d      = trdd_q;
    msg_done_d  = 1'b0;
    enter_prep  = 1'b0;
    sample_load = 1'b0;
    start       = trd_q & ~trdd_q;
    done_d      = (state_q == ST_IDLE) ? 1'b0 : (done_q | i_gen_done);

    if (wb) begin
      trd_d  = i_transmit;
      trdd_d = trd_q;
      case (state_q)
        ST_IDLE: begin
          tx_data_d = IDLE_WORD;
          if (start) begin
            cnt_d      = '0;
            state_d    = ST_PREPARE;
            enter_prep = 1'b1;
          end
        end
        ST_PREPARE: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            tx_data_d   = pack_sample(i_sample_i, i_sample_q);
            sample_load = 1'b1;
            state_d     = ST_TRANSMIT;
          end
        end
        ST_TRANSMIT: begin
          if (done_q) begin
            tx_data_d  = END_MARKER;
            msg_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            tx_data_d  = IDLE_WORD;
            cnt_d      = '0;
            state_d    = ST_PREPARE;
            enter_prep = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A generator that already reported done must not be stepped again.
    gen_en_d = enter_prep & ~done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= IDLE_WORD;
      cnt_q      <= '0;
      trd_q      <= 1'b0;
      trdd_q     <= 1'b0;
      done_q     <= 1'b0;
      gen_en_q   <= 1'b0;
      msg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      trd_q      <= trd_d;
      trdd_q     <= trdd_d;
      done_q     <= done_d;
      gen_en_q   <= gen_en_d;
      msg_done_q <= msg_done_d;
    end
  end

`ifdef LVDS_TX_SEQ_SAMPLE_CNT_EN
  logic [15:0] smp_cnt_q, smp_cnt_d;

  always_comb begin
    smp_cnt_d = smp_cnt_q;
    if (wb && (state_q == ST_IDLE) && start)
      smp_cnt_d = '0;
    else if (sample_load && (smp_cnt_q != 16'hFFFF))
      smp_cnt_d = smp_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) smp_cnt_q <= '0;
    else       smp_cnt_q <= smp_cnt_d;
  end

  assign o_sample_cnt = smp_cnt_q;
`endif

  assign o_gen_rst    = (state_q == ST_IDLE);
  assign o_ram_owner  = ~o_gen_rst;
  assign o_busy       = ~o_gen_rst;
  assign o_tx_data    = tx_data_q;
  assign o_gen_enable = gen_en_q;
  assign o_msg_done   = msg_done_q;

endmodule

// File: tb/tb_lvds_tx_sequencer.sv
// Self-checking bench for lvds_tx_sequencer: directed frame scenarios plus a
// randomized run compared against a boundary-level reference model.
module tb_lvds_tx_sequencer;

  localparam int SW = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_transmit, i_word_done, i_gen_done;
  logic [12:0] i_sample_i, i_sample_q;
  logic        o_gen_enable, o_gen_rst, o_ram_owner, o_msg_done, o_busy;
  logic [31:0] o_tx_data;
  logic [15:0] o_sample_cnt;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int period = 8;
  int en_seen = 0;
  int msg_seen = 0;

  // reference model state: mode 0 idle, 1 settling, 2 sample just sent
  int          m_mode, m_left;
  bit          m_prev_wd, m_tr1, m_tr2, m_done, m_genen, m_msg, m_wb;
  logic [31:0] m_data;
  int          m_cnt;

`ifndef LVDS_TX_SEQ_SAMPLE_CNT_EN
  assign o_sample_cnt = 16'h0;
`endif

  lvds_tx_sequencer #(.SETTLE_WORDS(SW), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_transmit   (i_transmit),
    .i_word_done  (i_word_done),
    .i_gen_done   (i_gen_done),
    .i_sample_i   (i_sample_i),
    .i_sample_q   (i_sample_q),
    .o_gen_enable (o_gen_enable),
    .o_gen_rst    (o_gen_rst),
    .o_ram_owner  (o_ram_owner),
    .o_tx_data    (o_tx_data),
`ifdef LVDS_TX_SEQ_SAMPLE_CNT_EN
    .o_sample_cnt (o_sample_cnt),
`endif
    .o_msg_done   (o_msg_done),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit wb, rising, new_done;
    m_genen = 0;
    m_msg   = 0;
    m_wb    = 0;
    if (reset) begin
      m_mode = 0; m_data = 0; m_prev_wd = 1; m_tr1 = 0; m_tr2 = 0;
      m_done = 0; m_cnt = 0; m_left = 0;
      return;
    end
    wb = i_word_done && !m_prev_wd;
    m_prev_wd = i_word_done;
    m_wb = wb;
    new_done = (m_mode != 0) && (m_done || i_gen_done);
    if (wb) begin
      rising = m_tr1 && !m_tr2;
      m_tr2 = m_tr1;
      m_tr1 = i_transmit;
      if (m_mode == 0) begin
        m_data = 0;
        if (rising) begin
          m_mode = 1; m_left = SW; m_cnt = 0; m_genen = 1;
        end
      end else if (m_mode == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_data = (32'd2 << 30) + (32'(i_sample_i) << 17) + (32'd1 << 16)
                 + (32'd1 << 14) + (32'(i_sample_q) << 1);
          if (m_cnt < 65535) m_cnt++;
          m_mode = 2;
        end
      end else begin
        if (m_done) begin
          m_data = 32'h8000_4000; m_msg = 1; m_mode = 0;
        end else begin
          m_data = 0; m_mode = 1; m_left = SW; m_genen = !new_done;
        end
      end
    end
    m_done = new_done;
  endtask

  task automatic tick();
    i_word_done = ((cyc_cnt % period) >= period / 2);
    model_step();
    @(posedge clk);
    #1;
    cyc_cnt++;
    en_seen  += int'(o_gen_enable);
    msg_seen += int'(o_msg_done);
  endtask

  // advance until the next tick will land on a word boundary
  task automatic to_pre_wb();
    while ((cyc_cnt % period) != period / 2) tick();
  endtask

  task automatic wait_boundaries(input int n);
    repeat (n) begin
      to_pre_wb();
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1; i_transmit = 0; i_gen_done = 0; i_sample_i = 0; i_sample_q = 0;
    cyc_cnt = 4;
    repeat (3) tick();
    reset = 0;
    tick();
    checks++;
    if (o_tx_data !== 32'h0) begin errors++; $display("FAIL reset_tx_data got %h exp %h", o_tx_data, 32'h0); end
    checks++;
    if (o_gen_rst !== 1'b1 || o_busy !== 1'b0 || o_ram_owner !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got rst=%b busy=%b own=%b exp 1 0 0", o_gen_rst, o_busy, o_ram_owner);
    end
    checks++;
    if (o_gen_enable !== 1'b0 || o_msg_done !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got en=%b msg=%b exp 0 0", o_gen_enable, o_msg_done);
    end
`ifdef LVDS_TX_SEQ_SAMPLE_CNT_EN
    checks++;
    if (o_sample_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", o_sample_cnt); end
`endif
  endtask

  task automatic test_idle();
    for (int c = 0; c < 64; c++) begin
      tick();
      checks++;
      if (o_tx_data !== 32'h0 || o_ram_owner !== 1'b0 || o_gen_enable !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc %0d got data=%h own=%b en=%b busy=%b exp 0 0 0 0", c, o_tx_data, o_ram_owner, o_gen_enable, o_busy);
      end
    end
  endtask

  task automatic test_sample_word();
    i_sample_i = 13'h1ABC;
    i_sample_q = 13'h0123;
    wait_boundaries(1);
    i_transmit = 1;
    en_seen = 0;
    wait_boundaries(10);
    checks++;
    if (o_tx_data !== 32'h0) begin errors++; $display("FAIL sample_pre got %h exp %h", o_tx_data, 32'h0); end
    wait_boundaries(1);
    checks++;
    if (o_tx_data !== 32'hB579_4246) begin errors++; $display("FAIL sample_word got %h exp %h", o_tx_data, 32'hB5794246); end
    checks++;
    if (en_seen !== 1) begin errors++; $display("FAIL sample_gen_en got %0d pulses exp 1", en_seen); end
    checks++;
    if (o_ram_owner !== 1'b1 || o_busy !== 1'b1) begin
      errors++; $display("FAIL sample_owner got own=%b busy=%b exp 1 1", o_ram_owner, o_busy);
    end
  endtask

  task automatic test_gen_done();
    en_seen = 0; msg_seen = 0;
    wait_boundaries(1);
    checks++;
    if (o_tx_data !== 32'h0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL gd_return got data=%h busy=%b exp 0 1", o_tx_data, o_busy);
    end
    wait_boundaries(2);
    i_gen_done = 1;
    tick();
    i_gen_done = 0;
    wait_boundaries(7);
    checks++;
    if (o_tx_data !== 32'hB579_4246) begin errors++; $display("FAIL gd_second_word got %h exp %h", o_tx_data, 32'hB5794246); end
    wait_boundaries(1);
    checks++;
    if (o_tx_data !== 32'h8000_4000 || o_msg_done !== 1'b1) begin
      errors++; $display("FAIL gd_end_marker got data=%h msg=%b exp 80004000 1", o_tx_data, o_msg_done);
    end
    tick();
    checks++;
    if (o_msg_done !== 1'b0) begin errors++; $display("FAIL gd_msg_width got %b exp 0", o_msg_done); end
    wait_boundaries(1);
    checks++;
    if (o_tx_data !== 32'h0 || o_ram_owner !== 1'b0 || o_gen_rst !== 1'b1) begin
      errors++; $display("FAIL gd_idle got data=%h own=%b rst=%b exp 0 0 1", o_tx_data, o_ram_owner, o_gen_rst);
    end
    checks++;
    if (en_seen !== 1 || msg_seen !== 1) begin
      errors++; $display("FAIL gd_pulse_count got en=%0d msg=%0d exp 1 1", en_seen, msg_seen);
    end
  endtask

  task automatic test_held();
    en_seen = 0;
    for (int b = 0; b < 15; b++) begin
      wait_boundaries(1);
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL held_restart b %0d got busy=%b exp 0", b, o_busy); end
    end
    checks++;
    if (en_seen !== 0) begin errors++; $display("FAIL held_gen_en got %0d exp 0", en_seen); end
    i_transmit = 0;
    wait_boundaries(1);
    i_transmit = 1;
    wait_boundaries(1);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL held_capture got busy=%b exp 0", o_busy); end
    wait_boundaries(1);
    checks++;
    if (o_busy !== 1'b1 || o_gen_enable !== 1'b1) begin
      errors++; $display("FAIL held_restart_ok got busy=%b en=%b exp 1 1", o_busy, o_gen_enable);
    end
  endtask

  task automatic test_done_same_cycle();
    wait_boundaries(9);
    checks++;
    if (o_tx_data !== 32'hB579_4246) begin errors++; $display("FAIL same_word got %h exp %h", o_tx_data, 32'hB5794246); end
    en_seen = 0; msg_seen = 0;
    to_pre_wb();
    i_gen_done = 1;
    tick();
    i_gen_done = 0;
    checks++;
    if (o_tx_data !== 32'h0 || o_busy !== 1'b1 || o_msg_done !== 1'b0) begin
      errors++; $display("FAIL same_tx_bnd got data=%h busy=%b msg=%b exp 0 1 0", o_tx_data, o_busy, o_msg_done);
    end
    wait_boundaries(1);
    checks++;
    if (en_seen !== 0) begin errors++; $display("FAIL same_gen_en got %0d pulses exp 0", en_seen); end
    wait_boundaries(8);
    checks++;
    if (o_tx_data !== 32'hB579_4246) begin errors++; $display("FAIL same_word2 got %h exp %h", o_tx_data, 32'hB5794246); end
    wait_boundaries(1);
    checks++;
    if (o_tx_data !== 32'h8000_4000 || msg_seen !== 1) begin
      errors++; $display("FAIL same_end got data=%h msg=%0d exp 80004000 1", o_tx_data, msg_seen);
    end
    wait_boundaries(1);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL same_idle got busy=%b exp 0", o_busy); end
  endtask

  task automatic test_reset_mid();
    i_transmit = 0;
    wait_boundaries(1);
    i_transmit = 1;
    wait_boundaries(2);
    wait_boundaries(9);
    wait_boundaries(1);
    wait_boundaries(5);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got busy=%b exp 1", o_busy); end
`ifdef LVDS_TX_SEQ_SAMPLE_CNT_EN
    checks++;
    if (o_sample_cnt !== 16'd1) begin errors++; $display("FAIL rmid_cnt_pre got %0d exp 1", o_sample_cnt); end
`endif
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (o_tx_data !== 32'h0 || o_gen_rst !== 1'b1 || o_ram_owner !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL rmid got data=%h rst=%b own=%b busy=%b exp 0 1 0 0", o_tx_data, o_gen_rst, o_ram_owner, o_busy);
    end
`ifdef LVDS_TX_SEQ_SAMPLE_CNT_EN
    checks++;
    if (o_sample_cnt !== 16'd0) begin errors++; $display("FAIL rmid_cnt got %0d exp 0", o_sample_cnt); end
`endif
    i_transmit = 0;
  endtask

  task automatic test_random();
    int periods[4] = '{2, 3, 5, 8};
    int shown = 0;
    for (int p = 0; p < 4; p++) begin
      period = periods[p];
      for (int c = 0; c < 800; c++) begin
        i_sample_i = 13'($urandom);
        i_sample_q = 13'($urandom);
        i_gen_done = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 39) == 0) i_transmit = ~i_transmit;
        reset = ($urandom_range(0, 599) == 0);
        tick();
        checks++;
        if (o_tx_data !== m_data || o_gen_enable !== m_genen || o_msg_done !== m_msg ||
            o_busy !== (m_mode != 0) || o_gen_rst !== (m_mode == 0) || o_ram_owner !== (m_mode != 0)) begin
          errors++;
          if (shown < 20) begin
            shown++;
            $display("FAIL random p=%0d c=%0d got data=%h en=%b msg=%b busy=%b exp data=%h en=%b msg=%b busy=%b",
                     period, c, o_tx_data, o_gen_enable, o_msg_done, o_busy, m_data, m_genen, m_msg, m_mode != 0);
          end
        end
`ifdef LVDS_TX_SEQ_SAMPLE_CNT_EN
        checks++;
        if (o_sample_cnt !== 16'(m_cnt)) begin
          errors++;
          if (shown < 20) begin
            shown++;
            $display("FAIL random_cnt c=%0d got %0d exp %0d", c, o_sample_cnt, m_cnt);
          end
        end
`endif
      end
    end
    reset = 0; i_gen_done = 0;
  endtask

  initial begin
    i_word_done = 1; i_transmit = 0; i_gen_done = 0; reset = 1;
    i_sample_i = 0; i_sample_q = 0;
    test_reset();
    test_idle();
    test_sample_word();
    test_gen_done();
    test_held();
    test_done_same_cycle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
